// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: address width, timeout default,
// FSM state encoding and the latched instruction payload.
package fetch_sequencer_pkg;

  localparam int unsigned PC_W            = 9;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_F_OP   = 3'd1,
    ST_F_OP1  = 3'd2,
    ST_F_OP2  = 3'd3,
    ST_F_LAST = 3'd4,
    ST_START  = 3'd5,
    ST_EXEC   = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] operand1;
    logic [7:0] operand2;
  } instr_t;

  // Byte offset from PC that a fetch state puts on the ROM address bus.
  function automatic logic [1:0] fetch_offset(input state_e st);
    logic [1:0] off;
    off = 2'd0;
    case (st)
      ST_F_OP1: off = 2'd1;
      ST_F_OP2: off = 2'd2;
      default:  off = 2'd0;
    endcase
    return off;
  endfunction

  function automatic logic is_rom_read(input state_e st);
    return (st == ST_F_OP) || (st == ST_F_OP1) || (st == ST_F_OP2);
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_unit.sv
// Architectural PC register: jump load or modulo-2^PC_W advance by instruction
// size, where a zero size is treated as one byte and flagged.
module fetch_sequencer_pc_unit
  import fetch_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            sys_rst,
  input  logic            ld_en,
  input  logic            jmp_en,
  input  logic [PC_W-1:0] jmp_addr,
  input  logic [1:0]      instr_size,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next_c,
  output logic            size_zero_c
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] step_c;

  always_comb begin
    pc_d        = pc_q;
    size_zero_c = 1'b0;
    step_c      = (instr_size == 2'd0) ? PC_W'(1) : PC_W'(instr_size);
    if (ld_en) begin
      if (jmp_en) begin
        pc_d = jmp_addr;
      end else begin
        pc_d        = pc_q + step_c;
        size_zero_c = (instr_size == 2'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc        = pc_q;
  assign pc_next_c = pc_d;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads opcode + two operands from a synchronous
// ROM, starts the decoder, then advances, jumps or halts on dec_done.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic            clk,
  input  logic            sys_rst,
  input  logic            run,
  output logic            rom_rd_en,
  output logic [PC_W-1:0] rom_addr,
  input  logic [7:0]      rom_data,
  output logic [7:0]      instr_byte,
  output logic [7:0]      operand1,
  output logic [7:0]      operand2,
  output logic            cmd_start,
  input  logic            dec_done,
  input  logic [1:0]      instr_size,
  input  logic            jmp_en,
  input  logic [PC_W-1:0] jmp_addr,
  input  logic            pc_hlt,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            timeout_err,
  output logic            size_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  instr_t          instr_q, instr_d;
  logic            rom_rd_en_q, rom_rd_en_d;
  logic [PC_W-1:0] rom_addr_q, rom_addr_d;
  logic            cmd_start_q, cmd_start_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;
  logic            timeout_err_q, timeout_err_d;
  logic            size_err_q, size_err_d;

  logic            pc_ld_c;
  logic [PC_W-1:0] pc_next_c;
  logic            size_zero_c;

  fetch_sequencer_pc_unit u_pc_unit (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .ld_en       (pc_ld_c),
    .jmp_en      (jmp_en),
    .jmp_addr    (jmp_addr),
    .instr_size  (instr_size),
    .pc          (pc),
    .pc_next_c   (pc_next_c),
    .size_zero_c (size_zero_c)
  );

  // Next-state, byte latching, timeout counting and PC load control.
  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    instr_d       = instr_q;
    timeout_err_d = timeout_err_q;
    pc_ld_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_F_OP;
      end
      ST_F_OP: begin
        state_d = ST_F_OP1;
      end
      ST_F_OP1: begin
        instr_d.opcode = rom_data;
        state_d        = ST_F_OP2;
      end
      ST_F_OP2: begin
        instr_d.operand1 = rom_data;
        state_d          = ST_F_LAST;
      end
      ST_F_LAST: begin
        instr_d.operand2 = rom_data;
        state_d          = ST_START;
      end
      ST_START: begin
        tmo_d   = '0;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_done) begin
          if (pc_hlt) begin
            state_d = ST_HALT;
          end else begin
            pc_ld_c = 1'b1;
            state_d = run ? ST_F_OP : ST_IDLE;
          end
        end else if (tmo_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d       = ST_HALT;
          timeout_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs are derived from the next state so they line up with it.
  always_comb begin
    size_err_d  = size_err_q | size_zero_c;
    rom_rd_en_d = is_rom_read(state_d);
    rom_addr_d  = rom_addr_q;
    if (rom_rd_en_d) begin
      rom_addr_d = pc_next_c + PC_W'(fetch_offset(state_d));
    end
    cmd_start_d = (state_d == ST_START);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_HALT);
    halted_d    = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      tmo_q         <= '0;
      instr_q       <= '0;
      rom_rd_en_q   <= 1'b0;
      rom_addr_q    <= '0;
      cmd_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      size_err_q    <= 1'b0;
    end else begin
      tmo_q         <= tmo_d;
      instr_q       <= instr_d;
      rom_rd_en_q   <= rom_rd_en_d;
      rom_addr_q    <= rom_addr_d;
      cmd_start_q   <= cmd_start_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
      timeout_err_q <= timeout_err_d;
      size_err_q    <= size_err_d;
    end
  end

  assign rom_rd_en   = rom_rd_en_q;
  assign rom_addr    = rom_addr_q;
  assign instr_byte  = instr_q.opcode;
  assign operand1    = instr_q.operand1;
  assign operand2    = instr_q.operand2;
  assign cmd_start   = cmd_start_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign timeout_err = timeout_err_q;
  assign size_err    = size_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a synchronous ROM model; expected
// values are hand-derived from the cycle-level behaviour of the sequencer.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic            clk;
  logic            sys_rst;
  logic            run;
  logic            rom_rd_en;
  logic [PC_W-1:0] rom_addr;
  logic [7:0]      rom_data;
  logic [7:0]      instr_byte;
  logic [7:0]      operand1;
  logic [7:0]      operand2;
  logic            cmd_start;
  logic            dec_done;
  logic [1:0]      instr_size;
  logic            jmp_en;
  logic [PC_W-1:0] jmp_addr;
  logic            pc_hlt;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            halted;
  logic            timeout_err;
  logic            size_err;

  logic [7:0] mem [512];
  int n_chk;
  int n_pass;
  int n_fail;

  fetch_sequencer #(.TIMEOUT_CYC(64)) dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .run         (run),
    .rom_rd_en   (rom_rd_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr_byte  (instr_byte),
    .operand1    (operand1),
    .operand2    (operand2),
    .cmd_start   (cmd_start),
    .dec_done    (dec_done),
    .instr_size  (instr_size),
    .jmp_en      (jmp_en),
    .jmp_addr    (jmp_addr),
    .pc_hlt      (pc_hlt),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .timeout_err (timeout_err),
    .size_err    (size_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program ROM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (rom_rd_en) rom_data <= mem[rom_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (got === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance until cmd_start is seen; n returns the number of cycles taken.
  task automatic wait_cmd(output int n);
    n = 0;
    while (cmd_start !== 1'b1 && n < 20) begin
      tick();
      n = n + 1;
    end
    chk("cmd_start_seen", 32'(cmd_start), 1);
  endtask

  // From the START cycle: enter EXEC, present one dec_done, land on the next state.
  task automatic pulse_done(input logic [1:0] size, input logic jmp,
                            input logic [PC_W-1:0] addr, input logic hlt);
    tick();
    dec_done   = 1'b1;
    instr_size = size;
    jmp_en     = jmp;
    jmp_addr   = addr;
    pc_hlt     = hlt;
    tick();
    dec_done   = 1'b0;
    instr_size = 2'd0;
    jmp_en     = 1'b0;
    pc_hlt     = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;
    n_chk  = 0;
    n_pass = 0;
    n_fail = 0;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i ^ 'h5A);
    mem[0]     = 8'h01;
    mem[1]     = 8'h42;
    mem[2]     = 8'h99;
    mem[3]     = 8'h33;
    mem['h1FE] = 8'hBE;
    mem['h1FF] = 8'hAA;

    sys_rst = 1'b1; run = 1'b0; dec_done = 1'b0; instr_size = 2'd0;
    jmp_en = 1'b0; jmp_addr = '0; pc_hlt = 1'b0;
    tick(); tick();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_rd_en", 32'(rom_rd_en), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_cmd", 32'(cmd_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_errs", 32'({timeout_err, size_err}), 0);
    chk("rst_instr", 32'({instr_byte, operand1, operand2}), 0);

    // Sequential fetch from PC 0
    sys_rst = 1'b0; run = 1'b1;
    tick();
    chk("c1_rd_en", 32'(rom_rd_en), 1);
    chk("c1_addr", 32'(rom_addr), 0);
    chk("c1_busy", 32'(busy), 1);
    tick();
    chk("c2_addr", 32'(rom_addr), 1);
    tick();
    chk("c3_addr", 32'(rom_addr), 2);
    tick();
    chk("c4_rd_en", 32'(rom_rd_en), 0);
    chk("c4_cmd", 32'(cmd_start), 0);
    tick();
    chk("c5_cmd", 32'(cmd_start), 1);
    chk("c5_instr", 32'(instr_byte), 'h01);
    chk("c5_op1", 32'(operand1), 'h42);
    chk("c5_op2", 32'(operand2), 'h99);
    tick();
    chk("c6_cmd_one_shot", 32'(cmd_start), 0);
    tick(); tick(); tick();
    dec_done = 1'b1; instr_size = 2'd1;
    tick();
    dec_done = 1'b0; instr_size = 2'd0;
    chk("seq_pc", 32'(pc), 1);
    chk("seq_refetch_addr", 32'(rom_addr), 1);
    wait_cmd(n);
    chk("lat_done_to_cmd", n, 4);
    chk("seq2_bytes", 32'({instr_byte, operand1, operand2}), 'h429933);

    // Jump to 0x1FF, fetch wraps, then size-2 advance wraps
    pulse_done(2'd1, 1'b1, 9'h1FF, 1'b0);
    chk("jmp_pc", 32'(pc), 'h1FF);
    chk("jmp_addr0", 32'(rom_addr), 'h1FF);
    tick();
    chk("wrap_addr1", 32'(rom_addr), 'h000);
    tick();
    chk("wrap_addr2", 32'(rom_addr), 'h001);
    wait_cmd(n);
    chk("wrap_bytes", 32'({instr_byte, operand1, operand2}), 'hAA0142);
    pulse_done(2'd2, 1'b0, 9'h000, 1'b0);
    chk("size2_wrap_pc", 32'(pc), 'h001);

    // dec_done during START is ignored; the following EXEC one jumps to 0x010
    wait_cmd(n);
    dec_done = 1'b1; jmp_en = 1'b1; jmp_addr = 9'h062;
    tick();
    dec_done = 1'b0; jmp_en = 1'b0;
    chk("start_done_ignored_pc", 32'(pc), 'h001);
    chk("start_done_ignored_busy", 32'(busy), 1);
    dec_done = 1'b1; jmp_en = 1'b1; jmp_addr = 9'h010;
    tick();
    dec_done = 1'b0; jmp_en = 1'b0;
    chk("jmp10_pc", 32'(pc), 'h010);

    // Size zero advances by one and sets the sticky flag
    wait_cmd(n);
    chk("size_err_clear", 32'(size_err), 0);
    pulse_done(2'd0, 1'b0, 9'h000, 1'b0);
    chk("size0_pc", 32'(pc), 'h011);
    chk("size0_err", 32'(size_err), 1);

    // 0x1FE + 3 wraps to 0x001
    wait_cmd(n);
    pulse_done(2'd1, 1'b1, 9'h1FE, 1'b0);
    wait_cmd(n);
    chk("pc1fe_opcode", 32'(instr_byte), 'hBE);
    pulse_done(2'd3, 1'b0, 9'h000, 1'b0);
    chk("size3_wrap_pc", 32'(pc), 'h001);
    chk("size_err_sticky", 32'(size_err), 1);

    // run low at dec_done parks in IDLE; fetch resumes when run returns
    wait_cmd(n);
    run = 1'b0;
    pulse_done(2'd1, 1'b0, 9'h000, 1'b0);
    chk("idle_pc", 32'(pc), 'h002);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_rd_en", 32'(rom_rd_en), 0);
    tick(); tick(); tick();
    chk("idle_stays", 32'({busy, rom_rd_en, cmd_start}), 0);
    run = 1'b1;
    tick();
    chk("resume_rd_en", 32'(rom_rd_en), 1);
    chk("resume_addr", 32'(rom_addr), 'h002);

    // Halt outranks jump; HALT ignores everything but reset
    wait_cmd(n);
    pulse_done(2'd1, 1'b1, 9'h062, 1'b1);
    chk("halt_halted", 32'(halted), 1);
    chk("halt_busy", 32'(busy), 0);
    chk("halt_pc", 32'(pc), 'h002);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      dec_done = (i == 3);
      jmp_en   = (i == 3);
      jmp_addr = 9'h062;
      tick();
      if (rom_rd_en || cmd_start) cnt = cnt + 1;
    end
    dec_done = 1'b0; jmp_en = 1'b0;
    chk("halt_quiet", cnt, 0);
    chk("halt_pc_hold", 32'(pc), 'h002);
    chk("halt_absorbing", 32'(halted), 1);

    sys_rst = 1'b1;
    tick();
    chk("rst_halt_clear", 32'(halted), 0);
    chk("rst_pc_zero", 32'(pc), 0);
    chk("rst_size_err", 32'(size_err), 0);

    // Reset asserted during F_OP2 returns to IDLE with no start pulse
    sys_rst = 1'b0;
    tick(); tick(); tick();
    chk("midrst_in_fop2", 32'(rom_addr), 2);
    sys_rst = 1'b1;
    tick();
    chk("midrst_idle", 32'({busy, rom_rd_en, cmd_start}), 0);
    sys_rst = 1'b0; run = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cmd_start || busy) cnt = cnt + 1;
    end
    chk("midrst_no_cmd", cnt, 0);

    // Withheld dec_done: 64 EXEC cycles, then timeout halt
    run = 1'b1;
    wait_cmd(n);
    repeat (64) tick();
    chk("tmo_not_yet", 32'({halted, busy}), 'b01);
    tick();
    chk("tmo_halted", 32'(halted), 1);
    chk("tmo_err", 32'(timeout_err), 1);
    chk("tmo_pc", 32'(pc), 0);
    sys_rst = 1'b1;
    tick();
    chk("tmo_rst_clear", 32'({halted, timeout_err}), 0);
    chk("tmo_rst_pc", 32'(pc), 0);
    sys_rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front-end controller that sequences the instruction decoder.
- Fetches opcode plus two operand bytes from the synchronous program ROM at the current PC, presents them to the decoder and pulses cmd_start. Waits for the decoder to finish, then advances the PC by instr_size, takes a jump, or halts.
- Sits between program ROM and decoder; owns the architectural PC.

Parameters:
- PC_W, 9, PC / ROM address width (512-byte program space, matches jmp_addr width).
- TIMEOUT_CYC, 64, max cycles in EXEC waiting for dec_done before a timeout halt.

Ports:
- clk  in  1  system clock
- sys_rst  in  1  synchronous active-high reset
- run  in  1  level; allows fetching to begin/continue
- rom_rd_en  out  1  ROM read strobe; data valid the cycle after
- rom_addr  out  PC_W  ROM byte address
- rom_data  in  8  ROM read data
- instr_byte  out  8  latched opcode to decoder
- operand1  out  8  latched byte at PC+1
- operand2  out  8  latched byte at PC+2
- cmd_start  out  1  one-cycle start pulse to decoder
- dec_done  in  1  decoder finished current instruction (one-cycle pulse)
- instr_size  in  2  bytes consumed by the instruction, valid with dec_done
- jmp_en  in  1  take jump, valid with dec_done
- jmp_addr  in  PC_W  jump target
- pc_hlt  in  1  halt request, valid with dec_done
- pc  out  PC_W  current PC
- busy  out  1  high in any state except IDLE/HALT
- halted  out  1  high in HALT
- timeout_err  out  1  sticky; set on EXEC timeout
- size_err  out  1  sticky; set when instr_size==0 seen with dec_done

Behaviour:
- Reset (sync, sys_rst=1 at posedge):
  - state=IDLE; pc=0; instr_byte/operand1/operand2=0.
  - cmd_start, rom_rd_en, busy, halted, timeout_err, size_err all 0.
  - rom_addr=0; timeout counter=0.
  - Overrides everything, including mid-fetch and mid-EXEC; no cmd_start may follow reset without a fresh fetch.
- All outputs registered or decoded from registered state; no input-to-output combinational path.
- States: IDLE, F_OP, F_OP1, F_OP2, F_LAST, START, EXEC, HALT.
- IDLE: run=1 -> F_OP; else stay.
- F_OP: rom_rd_en=1, rom_addr=pc -> F_OP1.
- F_OP1: rom_rd_en=1, rom_addr=pc+1; latch rom_data into instr_byte -> F_OP2.
- F_OP2: rom_rd_en=1, rom_addr=pc+2; latch rom_data into operand1 -> F_LAST.
- F_LAST: rom_rd_en=0; latch rom_data into operand2 -> START.
- START: cmd_start=1 for exactly this cycle; timeout counter cleared -> EXEC.
- EXEC, on dec_done=1, priority in this order:
  - pc_hlt -> HALT, pc unchanged.
  - else jmp_en -> pc=jmp_addr.
  - else pc = pc + (instr_size==0 ? 1 : instr_size); instr_size==0 also sets size_err.
  - Non-halt next state: run=1 -> F_OP, else IDLE.
- EXEC timeout: no dec_done for TIMEOUT_CYC cycles after START -> HALT, timeout_err=1, pc unchanged.
- instr_byte/operand1/operand2 hold stable from F_LAST until the next fetch's latch cycles.
- HALT: absorbing; only sys_rst leaves. dec_done, run and jmp_en are ignored.
- Address arithmetic is modulo 2^PC_W:
  - pc=511 fetches bytes 511, 0, 1.
  - pc=510 + size 3 -> pc=1.
- Latency:
  - sys_rst release with run=1: F_OP on the first cycle; cmd_start high on the 5th cycle.
  - dec_done in cycle N: F_OP at N+1; cmd_start high at N+5.
- run dropping mid-fetch does not abort; it is sampled only in IDLE and at dec_done.
- dec_done outside EXEC is ignored.

Decomposition:
- Shared cpu_pkg holds:
  - state encoding localparams (ST_IDLE..ST_HALT, 3-bit)
  - PC_W
  - default TIMEOUT_CYC
- One natural sub-module: pc_unit. Holds the PC register, wrap-around add, jump/size select and the size==0 fix-up; the FSM drives its load/advance controls.

Test Plan:
- Sequential fetch:
  - Stimulus: ROM[0..2]=01,42,99; run=1; dec_done with size=1 four cycles after cmd_start.
  - Response: instr_byte=01, operand1=42, operand2=99 at cmd_start (5th cycle after reset); pc=1; next cmd_start exactly 5 cycles after dec_done.
- Size-2 advance and wrap:
  - Stimulus: jmp_en=1, jmp_addr=0x1FF; then size=2.
  - Response: fetch addresses 1FF, 000, 001; pc=0x001.
- Jump vs halt priority:
  - Stimulus: dec_done with jmp_en=1, jmp_addr=0x062, pc_hlt=1.
  - Response: HALT, pc unchanged, halted=1; no further rom_rd_en or cmd_start for 20 cycles.
- Timeout:
  - Stimulus: withhold dec_done after cmd_start.
  - Response: halted=1 and timeout_err=1 after 64 cycles; sys_rst clears both, pc=0.
- Reset mid-operation / run gating:
  - Stimulus: assert sys_rst during F_OP2.
  - Response: next cycle state IDLE, cmd_start never pulses.
  - Stimulus: run=0 at dec_done.
  - Response: IDLE, busy=0; fetch resumes on run=1.
- Size zero:
  - Stimulus: dec_done with instr_size=0 at pc=0x010.
  - Response: pc=0x011, size_err=1 (sticky).
